// File: rtl/monolith_stream_pkg.sv
// Shared types and helpers for the Monolith stream front-end.
// Holds the FSM encoding and the Mersenne prime helper.
package monolith_stream_pkg;

    typedef logic [63:0] word_t;

    typedef enum logic [1:0] {
        LOAD,
        START,
        WAIT,
        DRAIN
    } fsm_state_e;

    function automatic word_t mersenne_prime(input int w);
        word_t one;
        one = 64'd1;
        return (one << w) - one;
    endfunction

endpackage

// File: rtl/mersenne_reduce.sv
// Folds a DATA_W-bit word into the field GF(2^WORD_W - 1).
// The result is always strictly below the prime.
module mersenne_reduce
    import monolith_stream_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int WORD_W = 31
) (
    input  logic [DATA_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    localparam logic [WORD_W:0] P = (WORD_W+1)'(mersenne_prime(WORD_W));

    logic [WORD_W:0] lo;
    logic [WORD_W:0] hi;
    logic [WORD_W:0] r0;
    logic [WORD_W:0] r1;
    logic [WORD_W:0] r2;

    assign lo = {1'b0, x[WORD_W-1:0]};

    generate
        if (DATA_W > WORD_W) begin : g_hi
            assign hi = (WORD_W+1)'(x[DATA_W-1:WORD_W]);
        end else begin : g_nohi
            assign hi = '0;
        end
    endgenerate

    // Fold high part onto low part, then up to two conditional subtracts.
    always_comb begin
        r0 = lo + hi;
        r1 = (r0 >= P) ? r0 - P : r0;
        r2 = (r1 >= P) ? r1 - P : r1;
        y  = r2[WORD_W-1:0];
    end

endmodule

// File: rtl/monolith_stream_wrapper.sv
// AXI-Stream framing around the Monolith hash core.
// Loads one state, launches the core, drains the digest words.
module monolith_stream_wrapper
    import monolith_stream_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int WORD_W      = 31,
    parameter int STATE_WORDS = 16,
    parameter int OUT_WORDS   = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DATA_W-1:0]                   s_tdata,
    input  logic                                s_tvalid,
    output logic                                s_tready,
    input  logic                                s_tlast,
    output logic [WORD_W-1:0]                   m_tdata,
    output logic                                m_tvalid,
    input  logic                                m_tready,
    output logic                                m_tlast,
    output logic [STATE_WORDS-1:0][WORD_W-1:0]  core_state_in,
    output logic                                core_start,
    input  logic [STATE_WORDS-1:0][WORD_W-1:0]  core_state_out,
    input  logic                                core_done,
    output logic                                err_short,
    output logic                                err_long
);

    localparam int IDX_W = (STATE_WORDS > 1) ? $clog2(STATE_WORDS) : 1;
    localparam logic [IDX_W-1:0] IN_LAST  = IDX_W'(STATE_WORDS - 1);
    localparam logic [IDX_W-1:0] OUT_LAST = IDX_W'(OUT_WORDS - 1);

    fsm_state_e state;
    fsm_state_e state_nx;

    logic                               armed;
    logic [IDX_W-1:0]                   in_idx;
    logic [IDX_W-1:0]                   out_idx;
    logic [STATE_WORDS-1:0][WORD_W-1:0] in_buf;
    logic [STATE_WORDS-1:0][WORD_W-1:0] out_buf;
    logic [WORD_W-1:0]                  s_word;
    logic                               s_fire;
    logic                               m_fire;
    logic                               in_at_end;
    logic                               out_at_end;
    logic                               frame_end;

    mersenne_reduce #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W)
    ) u_reduce (
        .x (s_tdata),
        .y (s_word)
    );

    assign core_state_in = in_buf;

    // Handshake qualifiers and stream outputs decoded from the state.
    always_comb begin
        s_tready   = (state == LOAD) && armed;
        m_tvalid   = (state == DRAIN);
        core_start = (state == START);
        in_at_end  = (in_idx == IN_LAST);
        out_at_end = (out_idx == OUT_LAST);
        m_tlast    = m_tvalid && out_at_end;
        m_tdata    = m_tvalid ? out_buf[out_idx] : '0;
        s_fire     = s_tvalid && s_tready;
        m_fire     = m_tvalid && m_tready;
        frame_end  = s_fire && (s_tlast || in_at_end);
    end

    // Next-state selection for load / start / wait / drain.
    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (frame_end) state_nx = START;
            START:   state_nx = WAIT;
            WAIT:    if (core_done) state_nx = DRAIN;
            DRAIN:   if (m_fire && out_at_end) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // State register; armed keeps s_tready low until the first edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
        end
    end

    // Input buffer fill, zero padding of short frames, sticky errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_idx    <= '0;
            in_buf    <= '0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else if (s_fire) begin
            in_buf[in_idx] <= s_word;
            in_idx <= frame_end ? '0 : in_idx + 1'b1;
            if (s_tlast && !in_at_end) begin
                err_short <= 1'b1;
                for (int i = 0; i < STATE_WORDS; i++) begin
                    if (IDX_W'(i) > in_idx) in_buf[i] <= '0;
                end
            end
            if (!s_tlast && in_at_end) err_long <= 1'b1;
        end
    end

    // Digest capture on core completion and output word walk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_buf <= '0;
            out_idx <= '0;
        end else if ((state == WAIT) && core_done) begin
            out_buf <= core_state_out;
            out_idx <= '0;
        end else if (m_fire && !out_at_end) begin
            out_idx <= out_idx + 1'b1;
        end
    end

endmodule

// File: doc/monolith_stream_wrapper.md
Name: monolith_stream_wrapper

Overview:
AXI-Stream front-end for the Monolith hash core, parametrised in word width, state size and digest length. It accepts one frame of STATE_WORDS input words on a slave stream and reduces each word into the Mersenne prime field. It then launches the hash core with a start/done handshake and streams the first OUT_WORDS state words out on a master stream with TLAST. It replaces the free-running serial loader with proper backpressure, framing and error flags.

Parameters:
DATA_W, 32, s_tdata width; legal range WORD_W..2*WORD_W
WORD_W, 31, field element width; field prime P = 2^WORD_W - 1
STATE_WORDS, 16, words per permutation state
OUT_WORDS, 16, words emitted per frame (1..STATE_WORDS); 8 gives a compression digest

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-low reset
s_tdata  in  DATA_W  input word
s_tvalid  in  1  input valid
s_tready  out  1  input ready
s_tlast  in  1  input frame end
m_tdata  out  WORD_W  output word
m_tvalid  out  1  output valid
m_tready  in  1  output ready
m_tlast  out  1  marks output word OUT_WORDS-1
core_state_in  out  STATE_WORDS x WORD_W  state to core
core_start  out  1  one-cycle launch pulse
core_state_out  in  STATE_WORDS x WORD_W  permuted state
core_done  in  1  one-cycle completion pulse
err_short  out  1  sticky: frame ended early and was zero-padded
err_long  out  1  sticky: TLAST missing on word STATE_WORDS-1

Behaviour:
- Reset (reset=0, async): FSM=LOAD; in_idx=0; out_idx=0; state buffers cleared; s_tready=0; m_tvalid=0; m_tlast=0; m_tdata=0; core_start=0; err_short=0; err_long=0. s_tready asserts on the first clock edge after reset is released.
- FSM states: LOAD -> START -> WAIT -> DRAIN -> LOAD.
- LOAD:
  - s_tready=1.
  - Each s_tvalid&s_tready cycle writes reduce(s_tdata) to in_buf[in_idx], then in_idx increments.
  - Frame completes on acceptance of word STATE_WORDS-1 or on any accepted word with s_tlast=1, whichever comes first.
  - Early TLAST: remaining entries are zero-filled in the same edge and err_short sets.
  - Word STATE_WORDS-1 accepted without TLAST: err_long sets; the frame still completes. Subsequent words belong to the next frame.
- START: lasts one cycle, core_start=1, s_tready=0. core_state_in is driven from in_buf continuously and is stable from START until core_done.
- WAIT: wait for core_done. On that edge, latch core_state_out into out_buf, set out_idx=0, enter DRAIN. core_done arriving outside WAIT is ignored.
- DRAIN:
  - m_tvalid=1 and m_tdata=out_buf[out_idx].
  - m_tlast=1 exactly when out_idx==OUT_WORDS-1.
  - m_tdata and m_tlast stay stable while m_tvalid&!m_tready.
  - On the final handshake go to LOAD with in_idx=0; s_tready=1 in the following cycle.
- Latency: last input handshake at edge N -> core_start high in cycle N+1. core_done at edge D -> first m_tvalid in cycle D+1.
- Reduction (combinational, before the in_buf register):
  - hi = x>>WORD_W, lo = x[WORD_W-1:0], r = lo + hi (WORD_W+1 bits).
  - If r >= P, subtract P, possibly twice, so the result is always < P. The value P itself maps to 0.
- Error flags clear only on reset.
- Reset mid-frame or mid-drain aborts the frame immediately. No partial output continues after release.
- The stream interfaces are half-duplex: no new input is accepted until DRAIN finishes.

Decomposition:
- Package monolith_stream_pkg: fsm_state_e enum (LOAD, START, WAIT, DRAIN); function mersenne_prime(WORD_W); typedef word_t.
- Sub-module mersenne_reduce, parametrised by DATA_W and WORD_W: combinational fold plus conditional subtract, instantiated once on the input path.

Test Plan:
- Frame of values 0..15 with TLAST on word 15, core model = identity with done 5 cycles after start -> core_state_in = 0..15; core_start pulses once; m_tdata = 0..15 with m_tlast only on word 15; no errors.
- Inputs 0xFFFFFFFF, 0x7FFFFFFF, 0x80000000, 0x7FFFFFFE -> stored values 1, 0, 1, 0x7FFFFFFE.
- Randomised m_tready (50%) and s_tvalid gaps -> no word lost or duplicated; m_tdata stable while stalled; s_tready=0 from START until the last output handshake.
- 4-word frame 0xA,0xB,0xC,0xD with TLAST on word 3 -> core_state_in = A,B,C,D followed by twelve zeros; err_short=1, err_long=0.
- 17 words with no TLAST -> first 16 words form frame 1 with err_long=1; word 17 becomes word 0 of frame 2. OUT_WORDS=8 build -> 8 outputs per frame, m_tlast on the 8th.
- Assert reset=0 during DRAIN at out_idx=3 -> m_tvalid=0 immediately (async); after release s_tready=1 and a fresh frame hashes correctly.
